// File: rtl/vga_timing_gen.sv
// VGA timing generator.
// A clock divider produces a pixel-rate enable, which advances the pixel and
// line counters. The bright window is decoded combinationally from the counts.
// Sync outputs are registered one clock behind the counts, so they line up
// with a registered pixel-data stage downstream. frame_start is a registered
// pulse that is high while the counters first sit at (0,0) after a frame wrap.
module vga_timing_gen #(
    parameter int DIV     = 4,
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_ON    = 144,
    parameter int H_OFF   = 784,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_ON    = 35,
    parameter int V_OFF   = 515
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       pix_en,
    output logic       hSync,
    output logic       vSync,
    output logic       frame_start
);

    localparam logic [3:0] DIV_MAX = 4'(DIV - 1);
    localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_ON_W  = 10'(H_ON);
    localparam logic [9:0] H_OFF_W = 10'(H_OFF);
    localparam logic [9:0] V_ON_W  = 10'(V_ON);
    localparam logic [9:0] V_OFF_W = 10'(V_OFF);

    logic [3:0] div_r;
    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic       h_sync_r;
    logic       v_sync_r;
    logic       frame_start_r;

    logic       pix_en_s;
    logic       h_wrap_s;
    logic       v_wrap_s;
    logic       bright_s;

    // Decode the pixel enable, counter wrap points and the visible window.
    always_comb begin
        pix_en_s = 1'b0;
        h_wrap_s = 1'b0;
        v_wrap_s = 1'b0;
        bright_s = 1'b0;
        if (en && (div_r == DIV_MAX)) begin
            pix_en_s = 1'b1;
        end else begin
            pix_en_s = 1'b0;
        end
        if (h_cnt_r == H_MAX) begin
            h_wrap_s = 1'b1;
        end else begin
            h_wrap_s = 1'b0;
        end
        if (v_cnt_r == V_MAX) begin
            v_wrap_s = 1'b1;
        end else begin
            v_wrap_s = 1'b0;
        end
        if ((h_cnt_r >= H_ON_W) && (h_cnt_r < H_OFF_W) &&
            (v_cnt_r >= V_ON_W) && (v_cnt_r < V_OFF_W)) begin
            bright_s = 1'b1;
        end else begin
            bright_s = 1'b0;
        end
    end

    // Clock divider: free-runs 0..DIV-1 while enabled, holds its phase otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r <= 4'd0;
        end else if (en) begin
            if (div_r == DIV_MAX) begin
                div_r <= 4'd0;
            end else begin
                div_r <= div_r + 4'd1;
            end
        end else begin
            div_r <= div_r;
        end
    end

    // Pixel and line counters advance on the pixel enable and wrap at their totals.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (pix_en_s) begin
            if (h_wrap_s) begin
                h_cnt_r <= 10'd0;
                if (v_wrap_s) begin
                    v_cnt_r <= 10'd0;
                end else begin
                    v_cnt_r <= v_cnt_r + 10'd1;
                end
            end else begin
                h_cnt_r <= h_cnt_r + 10'd1;
                v_cnt_r <= v_cnt_r;
            end
        end else begin
            h_cnt_r <= h_cnt_r;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Active-low syncs track the counts every clock, one clock behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_sync_r <= 1'b1;
            v_sync_r <= 1'b1;
        end else begin
            h_sync_r <= ~(h_cnt_r < H_SYNC_W);
            v_sync_r <= ~(v_cnt_r < V_SYNC_W);
        end
    end

    // Frame-start pulse: set on the advance that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pix_en_s & h_wrap_s & v_wrap_s;
        end
    end

    assign hCount      = h_cnt_r;
    assign vCount      = v_cnt_r;
    assign bright      = bright_s;
    assign pix_en      = pix_en_s;
    assign hSync       = h_sync_r;
    assign vSync       = v_sync_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so whole frames
// fit in a short run. The reference model tracks the number of pixels emitted
// since reset and derives column/line from it arithmetically.
module tb_vga_timing_gen;

    localparam int DIV     = 3;
    localparam int H_TOTAL = 20;
    localparam int H_SYNC  = 3;
    localparam int H_ON    = 5;
    localparam int H_OFF   = 17;
    localparam int V_TOTAL = 8;
    localparam int V_SYNC  = 2;
    localparam int V_ON    = 2;
    localparam int V_OFF   = 7;
    localparam int FRAME_PIX = H_TOTAL * V_TOTAL;
    localparam int FRAME_CLK = FRAME_PIX * DIV;
    localparam int NCYC      = 6 * FRAME_CLK;

    logic       clk;
    logic       rst;
    logic       en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       pix_en;
    logic       hSync;
    logic       vSync;
    logic       frame_start;

    vga_timing_gen #(
        .DIV(DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_ON(H_ON), .H_OFF(H_OFF),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_ON(V_ON), .V_OFF(V_OFF)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .hCount(hCount), .vCount(vCount),
        .bright(bright), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
        .frame_start(frame_start)
    );

    typedef struct {
        int hc;
        int vc;
        int br;
        int pe;
        int hs;
        int vs;
        int fs;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;
    int exp_frames = 0;
    int dut_frames = 0;

    // reference model state
    int m_phase;
    int m_p;
    int m_hs;
    int m_vs;
    int m_fs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int col_of(input int p);
        return p % H_TOTAL;
    endfunction

    function automatic int line_of(input int p);
        return (p / H_TOTAL) % V_TOTAL;
    endfunction

    task automatic check(input string name, input int act, input int want);
        total = total + 1;
        if (act != want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_p     = 0;
        m_hs    = 1;
        m_vs    = 1;
        m_fs    = 0;
    endtask

    // State change at a rising edge given the rst/en values seen at that edge.
    task automatic model_edge(input logic r, input logic e);
        int adv;
        if (!r) begin
            model_reset();
        end else begin
            m_hs = (col_of(m_p) < H_SYNC) ? 0 : 1;
            m_vs = (line_of(m_p) < V_SYNC) ? 0 : 1;
            adv  = (e && (m_phase == DIV - 1)) ? 1 : 0;
            m_fs = (adv == 1 && ((m_p + 1) % FRAME_PIX) == 0) ? 1 : 0;
            if (e) m_phase = (m_phase + 1) % DIV;
            if (adv == 1) m_p = m_p + 1;
            if (m_fs == 1) exp_frames = exp_frames + 1;
        end
    endtask

    task automatic push_expected();
        exp_t x;
        int h;
        int v;
        h = col_of(m_p);
        v = line_of(m_p);
        x.hc = h;
        x.vc = v;
        x.br = (h >= H_ON && h < H_OFF && v >= V_ON && v < V_OFF) ? 1 : 0;
        x.pe = (rst && en && m_phase == DIV - 1) ? 1 : 0;
        x.hs = m_hs;
        x.vs = m_vs;
        x.fs = m_fs;
        exp_q.push_back(x);
    endtask

    // Monitor: compare the DUT outputs against the queued expectation each cycle.
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("hCount", int'(hCount), x.hc);
            check("vCount", int'(vCount), x.vc);
            check("bright", int'(bright), x.br);
            check("pix_en", int'(pix_en), x.pe);
            check("hSync", int'(hSync), x.hs);
            check("vSync", int'(vSync), x.vs);
            check("frame_start", int'(frame_start), x.fs);
            if (frame_start === 1'b1) dut_frames = dut_frames + 1;
        end
    end

    // Stimulus: reset, steady run, then random enable with a freeze burst and a mid-frame reset.
    initial begin
        logic r_new;
        logic e_new;
        int rst_at;
        int freeze_at;
        rst = 1'b0;
        en  = 1'b0;
        model_reset();
        rst_at    = 4 * FRAME_CLK + 137 + int'($urandom_range(0, 200));
        freeze_at = 3 * FRAME_CLK + 50;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            model_edge(rst, en);
            r_new = 1'b1;
            e_new = 1'b1;
            if (c < 4) begin
                r_new = 1'b0;
                e_new = 1'b0;
            end else if (c < 4 + 2 * FRAME_CLK + 10) begin
                e_new = 1'b1;
            end else if (c >= freeze_at && c < freeze_at + 10) begin
                e_new = 1'b0;
            end else if (c >= rst_at && c < rst_at + 3) begin
                r_new = 1'b0;
                e_new = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            end else begin
                e_new = ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0;
            end
            if (!r_new) model_reset();
            rst = r_new;
            en  = e_new;
            push_expected();
        end
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("frame_count", dut_frames, exp_frames);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
